// File: rtl/ysyx_22040750_npc_ctrl_pkg.sv
// Shared constants for the next-PC controller: one-hot select bit indices,
// controller state encoding and the default reset PC.
package ysyx_22040750_pkg;

   localparam int SEL_SNPC = 0;
   localparam int SEL_BR   = 1;
   localparam int SEL_JAL  = 2;
   localparam int SEL_JALR = 3;
   localparam int SEL_CSR  = 4;
   localparam int SEL_W    = 5;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

   typedef enum logic {
      EMPTY = 1'b0,
      HELD  = 1'b1
   } npc_state_e;

endpackage

// File: rtl/ysyx_22040750_npc_ctrl_if.sv
// ID/trap -> next-PC controller -> IF bundle. The controller takes the slave
// modport; the ID/IF environment takes master. O_misalign exists only with
// YSYX_22040750_NPC_MISALIGN_EN defined.
interface ysyx_22040750_npc_ctrl_if
   import ysyx_22040750_pkg::*;
#(
   parameter int XLEN = 64,
   parameter int PC_W = 32
);
   logic              I_id_valid;
   logic              O_id_ready;
   logic [SEL_W-1:0]  I_sel;
   logic [PC_W-1:0]   I_pc;
   logic [PC_W-1:0]   I_snpc;
   logic [XLEN-1:0]   I_rs1_data;
   logic [XLEN-1:0]   I_imm;
   logic [XLEN-1:0]   I_csr_pc;
   logic              I_trap_valid;
   logic [XLEN-1:0]   I_trap_pc;
   logic              I_flush;
   logic              O_dnpc_valid;
   logic              I_pc_ready;
   logic [PC_W-1:0]   O_dnpc;
   logic              O_held;
`ifdef YSYX_22040750_NPC_MISALIGN_EN
   logic              O_misalign;
`endif

   modport slave (
      input  I_id_valid, I_sel, I_pc, I_snpc, I_rs1_data, I_imm, I_csr_pc,
      input  I_trap_valid, I_trap_pc, I_flush, I_pc_ready,
`ifdef YSYX_22040750_NPC_MISALIGN_EN
      output O_misalign,
`endif
      output O_id_ready, O_dnpc_valid, O_dnpc, O_held
   );

   modport master (
      output I_id_valid, I_sel, I_pc, I_snpc, I_rs1_data, I_imm, I_csr_pc,
      output I_trap_valid, I_trap_pc, I_flush, I_pc_ready,
`ifdef YSYX_22040750_NPC_MISALIGN_EN
      input  O_misalign,
`endif
      input  O_id_ready, O_dnpc_valid, O_dnpc, O_held
   );

endinterface

// File: rtl/ysyx_22040750_npc_ctrl_target.sv
// Combinational next-PC target: shared adder plus priority select
// trap > csr > jalr > jal/branch > snpc.
module ysyx_22040750_npc_target
   import ysyx_22040750_pkg::*;
#(
   parameter int XLEN = 64,
   parameter int PC_W = 32
) (
   input  logic [SEL_W-1:0] sel_i,
   input  logic [PC_W-1:0]  pc_i,
   input  logic [PC_W-1:0]  snpc_i,
   input  logic [XLEN-1:0]  rs1_i,
   input  logic [XLEN-1:0]  imm_i,
   input  logic [XLEN-1:0]  csr_pc_i,
   input  logic             trap_valid_i,
   input  logic [XLEN-1:0]  trap_pc_i,
   output logic [PC_W-1:0]  target_o,
   output logic             misalign_o
);
   logic [XLEN-1:0] base;
   logic [XLEN-1:0] sum;
   logic            unused_bits;

   assign base = sel_i[SEL_JALR] ? rs1_i : XLEN'(pc_i);
   assign sum  = imm_i + base;

   always_comb begin
      target_o = snpc_i;
      if (trap_valid_i) begin
         target_o = trap_pc_i[PC_W-1:0];
      end else if (sel_i[SEL_CSR]) begin
         target_o = csr_pc_i[PC_W-1:0];
      end else if (sel_i[SEL_JALR]) begin
         target_o = {sum[PC_W-1:1], 1'b0};
      end else if (sel_i[SEL_JAL] || sel_i[SEL_BR]) begin
         target_o = sum[PC_W-1:0];
      end
   end

   // Trap targets come from mtvec and are never flagged here.
   assign misalign_o = !trap_valid_i && (target_o[1:0] != 2'b00);

   assign unused_bits = ^{csr_pc_i, trap_pc_i, sum};

endmodule

// File: rtl/ysyx_22040750_npc_ctrl.sv
// Next-PC controller: zero-latency target on a valid/ready handshake with a
// one-entry hold register. Optional YSYX_22040750_NPC_MISALIGN_EN adds O_misalign.
module ysyx_22040750_npc_ctrl
   import ysyx_22040750_pkg::*;
#(
   parameter int              XLEN     = 64,
   parameter int              PC_W     = 32,
   parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEFAULT)
) (
   input  logic I_clk,
   input  logic I_rst_n,
   ysyx_22040750_npc_ctrl_if.slave bus
);
   npc_state_e      state_q, state_d;
   logic [PC_W-1:0] hold_q, hold_d;
   logic [PC_W-1:0] target;
   logic            target_misalign;
   logic [PC_W-1:0] dnpc;
   logic            dnpc_valid;
   logic            req;

   ysyx_22040750_npc_target #(
      .XLEN (XLEN),
      .PC_W (PC_W)
   ) u_target (
      .sel_i        (bus.I_sel),
      .pc_i         (bus.I_pc),
      .snpc_i       (bus.I_snpc),
      .rs1_i        (bus.I_rs1_data),
      .imm_i        (bus.I_imm),
      .csr_pc_i     (bus.I_csr_pc),
      .trap_valid_i (bus.I_trap_valid),
      .trap_pc_i    (bus.I_trap_pc),
      .target_o     (target),
      .misalign_o   (target_misalign)
   );

   assign req = bus.I_id_valid | bus.I_trap_valid;

`ifdef YSYX_22040750_NPC_MISALIGN_EN
   logic misalign_q, misalign_d;
`endif

   always_comb begin
      state_d    = state_q;
      hold_d     = hold_q;
      dnpc       = hold_q;
      dnpc_valid = 1'b0;
`ifdef YSYX_22040750_NPC_MISALIGN_EN
      misalign_d = misalign_q;
`endif
      case (state_q)
         EMPTY: begin
            dnpc_valid = req;
            if (req) begin
               dnpc = target;
            end
            if (req && !bus.I_pc_ready) begin
               state_d = HELD;
               hold_d  = target;
`ifdef YSYX_22040750_NPC_MISALIGN_EN
               misalign_d = target_misalign;
`endif
            end
         end
         HELD: begin
            // A trap replaces the held value even when a flush arrives with it.
            if (bus.I_trap_valid) begin
               dnpc       = target;
               dnpc_valid = 1'b1;
               if (bus.I_pc_ready) begin
                  state_d = EMPTY;
               end else begin
                  hold_d = target;
`ifdef YSYX_22040750_NPC_MISALIGN_EN
                  misalign_d = 1'b0;
`endif
               end
            end else if (bus.I_flush) begin
               dnpc_valid = bus.I_pc_ready;
               state_d    = EMPTY;
            end else begin
               dnpc_valid = 1'b1;
               if (bus.I_pc_ready) begin
                  state_d = EMPTY;
               end
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         state_q <= EMPTY;
         hold_q  <= RESET_PC;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
      end
   end

`ifdef YSYX_22040750_NPC_MISALIGN_EN
   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         misalign_q <= 1'b0;
      end else begin
         misalign_q <= misalign_d;
      end
   end

   always_comb begin
      bus.O_misalign = 1'b0;
      if (I_rst_n) begin
         if (state_q == HELD) begin
            bus.O_misalign = !bus.I_trap_valid && misalign_q;
         end else begin
            bus.O_misalign = req && target_misalign;
         end
      end
   end
`else
   logic unused_misalign;
   assign unused_misalign = target_misalign;
`endif

   // Reset gating keeps outputs quiet even before the first clock edge.
   assign bus.O_dnpc_valid = dnpc_valid & I_rst_n;
   assign bus.O_dnpc       = I_rst_n ? dnpc : RESET_PC;
   assign bus.O_id_ready   = (state_q == EMPTY);
   assign bus.O_held       = (state_q == HELD);

endmodule

// File: tb/tb_ysyx_22040750_npc_ctrl.sv
// Directed bench for the next-PC controller: expected PCs are queued when a
// request is driven and popped when IF takes O_dnpc.
module tb_ysyx_22040750_npc_ctrl;
   import ysyx_22040750_pkg::*;

   localparam int XLEN = 64;
   localparam int PC_W = 32;
   localparam logic [PC_W-1:0] RST_PC = 32'h8000_0000;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   logic [PC_W-1:0] exp_q[$];

   ysyx_22040750_npc_ctrl_if #(.XLEN(XLEN), .PC_W(PC_W)) bus ();

   ysyx_22040750_npc_ctrl #(.XLEN(XLEN), .PC_W(PC_W), .RESET_PC(RST_PC)) dut (
      .I_clk   (clk),
      .I_rst_n (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic pop_chk(input string tag);
      logic [PC_W-1:0] e;
      chk({tag, "_valid"}, 64'(bus.O_dnpc_valid), 64'd1);
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s scoreboard empty observed=%h", tag, bus.O_dnpc);
      end else begin
         e = exp_q.pop_front();
         chk(tag, 64'(bus.O_dnpc), 64'(e));
         $display("txn %-12s dnpc=%h expected=%h", tag, bus.O_dnpc, e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_id(input int sel_idx, input logic [PC_W-1:0] pc,
                           input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] imm,
                           input logic ready);
      bus.I_id_valid = 1'b1;
      bus.I_sel      = (sel_idx < 0) ? 5'b0 : 5'(5'b1 << sel_idx);
      bus.I_pc       = pc;
      bus.I_rs1_data = rs1;
      bus.I_imm      = imm;
      bus.I_pc_ready = ready;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      bus.I_id_valid = 1'b0;  bus.I_sel = '0;       bus.I_pc = '0;
      bus.I_snpc = '0;        bus.I_rs1_data = '0;  bus.I_imm = '0;
      bus.I_csr_pc = '0;      bus.I_trap_valid = 1'b0;
      bus.I_trap_pc = '0;     bus.I_flush = 1'b0;   bus.I_pc_ready = 1'b0;

      // Reset state, during and after reset
      repeat (2) @(negedge clk);
      chk("rst_valid", 64'(bus.O_dnpc_valid), 64'd0);
      chk("rst_dnpc", 64'(bus.O_dnpc), 64'(RST_PC));
      rst_n = 1'b1;
      #1;
      chk("rel_valid", 64'(bus.O_dnpc_valid), 64'd0);
      chk("rel_dnpc", 64'(bus.O_dnpc), 64'(RST_PC));
      chk("rel_held", 64'(bus.O_held), 64'd0);
      chk("rel_idrdy", 64'(bus.O_id_ready), 64'd1);

      // jal, zero latency, consumed immediately
      tick();
      drive_id(SEL_JAL, 32'h8000_0010, 64'h0, 64'h20, 1'b1);
      exp_q.push_back(32'h8000_0030);
      @(negedge clk);
      pop_chk("jal");
      tick();
      chk("jal_held", 64'(bus.O_held), 64'd0);

      // jalr with back-pressure; garbage id_valid in HELD must be ignored
      drive_id(SEL_JALR, 32'h0, 64'h8000_1003, 64'h4, 1'b0);
      exp_q.push_back(32'h8000_1006);
      @(negedge clk);
      chk("jalr_e_dnpc", 64'(bus.O_dnpc), 64'h8000_1006);
      chk("jalr_e_idrdy", 64'(bus.O_id_ready), 64'd1);
      tick();
      drive_id(SEL_JAL, 32'h1234_0000, 64'h0, 64'h0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("jalr_h_held", 64'(bus.O_held), 64'd1);
         chk("jalr_h_idrdy", 64'(bus.O_id_ready), 64'd0);
         chk("jalr_h_dnpc", 64'(bus.O_dnpc), 64'h8000_1006);
         tick();
      end
      bus.I_id_valid = 1'b0;
      bus.I_pc_ready = 1'b1;
      @(negedge clk);
      pop_chk("jalr");
      tick();
      chk("jalr_empty", 64'(bus.O_held), 64'd0);

      // Trap overrides held value
      drive_id(SEL_JAL, 32'h8000_0100, 64'h0, 64'h0, 1'b0);
      tick();
      bus.I_id_valid = 1'b0;
      @(negedge clk);
      chk("trap_pre", 64'(bus.O_dnpc), 64'h8000_0100);
      tick();
      bus.I_trap_valid = 1'b1;
      bus.I_trap_pc    = 64'h8000_0004;
      @(negedge clk);
      chk("trap_comb", 64'(bus.O_dnpc), 64'h8000_0004);
      chk("trap_valid", 64'(bus.O_dnpc_valid), 64'd1);
      tick();
      bus.I_trap_valid = 1'b0;
      bus.I_trap_pc    = '0;
      exp_q.push_back(32'h8000_0004);
      @(negedge clk);
      chk("trap_held", 64'(bus.O_held), 64'd1);
      tick();
      bus.I_pc_ready = 1'b1;
      @(negedge clk);
      pop_chk("trap");
      tick();
      chk("trap_empty", 64'(bus.O_held), 64'd0);

      // Flush drops held value
      bus.I_snpc = 32'h8000_0040;
      drive_id(SEL_SNPC, 32'h0, 64'h0, 64'h0, 1'b0);
      tick();
      bus.I_id_valid = 1'b0;
      bus.I_flush    = 1'b1;
      @(negedge clk);
      chk("flush_valid", 64'(bus.O_dnpc_valid), 64'd0);
      tick();
      bus.I_flush = 1'b0;
      chk("flush_held", 64'(bus.O_held), 64'd0);
      chk("flush_idrdy", 64'(bus.O_id_ready), 64'd1);
      bus.I_snpc = 32'h8000_0044;
      drive_id(SEL_SNPC, 32'h0, 64'h0, 64'h0, 1'b1);
      exp_q.push_back(32'h8000_0044);
      @(negedge clk);
      pop_chk("snpc");
      tick();

      // All-zero select falls back to snpc; csr path
      bus.I_snpc = 32'h8000_0048;
      drive_id(-1, 32'h8000_0500, 64'h0, 64'h100, 1'b1);
      exp_q.push_back(32'h8000_0048);
      @(negedge clk);
      pop_chk("sel_zero");
      tick();
      bus.I_csr_pc = 64'h8000_0200;
      drive_id(SEL_CSR, 32'h8000_0500, 64'h8000_0900, 64'h100, 1'b1);
      exp_q.push_back(32'h8000_0200);
      @(negedge clk);
      pop_chk("csr");
      tick();

      // Trap together with flush in HELD, IF ready
      drive_id(SEL_JAL, 32'h8000_0300, 64'h0, 64'h0, 1'b0);
      tick();
      bus.I_id_valid   = 1'b0;
      bus.I_trap_valid = 1'b1;
      bus.I_trap_pc    = 64'h8000_0008;
      bus.I_flush      = 1'b1;
      bus.I_pc_ready   = 1'b1;
      exp_q.push_back(32'h8000_0008);
      @(negedge clk);
      pop_chk("trap_flush");
      tick();
      bus.I_trap_valid = 1'b0;
      bus.I_flush      = 1'b0;
      chk("tf_empty", 64'(bus.O_held), 64'd0);

      // Asynchronous reset mid-HELD
      drive_id(SEL_JAL, 32'h8000_0600, 64'h0, 64'h0, 1'b0);
      tick();
      bus.I_id_valid = 1'b0;
      chk("arst_pre_held", 64'(bus.O_held), 64'd1);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_held", 64'(bus.O_held), 64'd0);
      chk("arst_valid", 64'(bus.O_dnpc_valid), 64'd0);
      chk("arst_dnpc", 64'(bus.O_dnpc), 64'(RST_PC));
      chk("arst_idrdy", 64'(bus.O_id_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

`ifdef YSYX_22040750_NPC_MISALIGN_EN
      drive_id(SEL_BR, 32'h8000_0020, 64'h0, 64'h2, 1'b0);
      exp_q.push_back(32'h8000_0022);
      @(negedge clk);
      chk("mis_e", 64'(bus.O_misalign), 64'd1);
      tick();
      bus.I_id_valid = 1'b0;
      @(negedge clk);
      chk("mis_h", 64'(bus.O_misalign), 64'd1);
      tick();
      bus.I_pc_ready = 1'b1;
      @(negedge clk);
      pop_chk("mis_br");
      tick();
      drive_id(SEL_BR, 32'h8000_0020, 64'h0, 64'h4, 1'b1);
      exp_q.push_back(32'h8000_0024);
      @(negedge clk);
      chk("mis_ok", 64'(bus.O_misalign), 64'd0);
      pop_chk("aligned_br");
      tick();
      bus.I_id_valid = 1'b0;
`endif

      chk("sb_drained", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
